// File: rtl/neo_zmc_pkg.sv
// Shared CR-format constants and the bitplane position helper used by the
// packer and by the ZMC2-side checkers.
package neo_zmc_pkg;

  localparam int CR_W   = 32;
  localparam int PIX_W  = 4;
  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;
  localparam int WCNT_W = 16;

  // Bit index of a pixel's plane bit in a CR word: plane selects the byte,
  // slot selects the column, flip mirrors the column (7-slot == ~slot).
  function automatic logic [4:0] cr_bitpos(input logic [SLOT_W-1:0] slot,
                                           input logic [1:0]        plane,
                                           input logic              flip);
    logic [SLOT_W-1:0] col;
    col = flip ? ~slot : slot;
    return {plane, col};
  endfunction

endpackage

// File: rtl/neo_crom_packer_if.sv
// Pixel-in / CR-word-out handshake bundle of the C-ROM packer.
interface neo_crom_packer_if;
  import neo_zmc_pkg::*;

  logic [PIX_W-1:0]  PIX;
  logic              PIX_VALID;
  logic              FLUSH;
  logic              H;
  logic              PIX_READY;
  logic [CR_W-1:0]   CR;
  logic              CR_VALID;
  logic              CR_READY;
  logic [WCNT_W-1:0] WCNT;

  modport master (output PIX, PIX_VALID, FLUSH, H, CR_READY,
                  input  PIX_READY, CR, CR_VALID, WCNT);

  modport slave  (input  PIX, PIX_VALID, FLUSH, H, CR_READY,
                  output PIX_READY, CR, CR_VALID, WCNT);
endinterface

// File: rtl/neo_crom_packer_outreg.sv
// One-deep CR word register with valid/ready handshake and emitted-word count.
module crp_outreg
  import neo_zmc_pkg::*;
(
  input  logic              CLK_12M,
  input  logic              nRESET,
  input  logic              load_i,
  input  logic [CR_W-1:0]   word_i,
  input  logic              cr_ready_i,
  output logic [CR_W-1:0]   cr_o,
  output logic              cr_valid_o,
  output logic [WCNT_W-1:0] wcnt_o
);

  logic [CR_W-1:0]   cr_q,       cr_d;
  logic              cr_valid_q, cr_valid_d;
  logic [WCNT_W-1:0] wcnt_q,     wcnt_d;

  // A new word wins over the handshake so back-to-back words keep valid high.
  always_comb begin
    cr_d       = cr_q;
    cr_valid_d = cr_valid_q;
    wcnt_d     = wcnt_q;
    if (cr_valid_q && cr_ready_i) cr_valid_d = 1'b0;
    if (load_i) begin
      cr_d       = word_i;
      cr_valid_d = 1'b1;
      wcnt_d     = wcnt_q + 16'd1;
    end
  end

  // Output register state.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      cr_q       <= '0;
      cr_valid_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      cr_q       <= cr_d;
      cr_valid_q <= cr_valid_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign cr_o       = cr_q;
  assign cr_valid_o = cr_valid_q;
  assign wcnt_o     = wcnt_q;

endmodule

// File: rtl/neo_crom_packer.sv
// Packs a stream of 4-bit pixel indexes into 32-bit C-ROM bitplane words.
module neo_crom_packer
  import neo_zmc_pkg::*;
(
  input  logic               CLK_12M,
  input  logic               nRESET,
  neo_crom_packer_if.slave   bus
);

  logic [CR_W-1:0]   acc_q,  acc_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              hf_q,   hf_d;

  logic              cr_valid;
  logic              stall;
  logic              pix_ready;
  logic              acc_pix;
  logic              acc_flush;
  logic              flip;
  logic              close;
  logic              last_slot;
  logic [CR_W-1:0]   pix_bits;
  logic [CR_W-1:0]   word_merge;

  assign last_slot = (slot_q == 3'd7);
  assign stall     = cr_valid & ~bus.CR_READY;
  // While stalled, only a non-closing pixel can still be absorbed.
  assign pix_ready = ~stall | (~last_slot & ~bus.FLUSH);
  assign acc_pix   = bus.PIX_VALID & pix_ready;
  assign acc_flush = bus.FLUSH & pix_ready;
  // The first pixel of a group uses H directly; later slots use the latch.
  assign flip      = (slot_q == '0) ? bus.H : hf_q;
  // A flush on an empty group with no pixel is a no-op.
  assign close     = (acc_pix & last_slot) | (acc_flush & (acc_pix | (slot_q != '0)));

  // Scatter the incoming pixel's four bits into their bitplane positions.
  always_comb begin
    pix_bits = '0;
    for (int p = 0; p < PIX_W; p++) begin
      pix_bits[cr_bitpos(slot_q, 2'(p), flip)] = bus.PIX[p];
    end
  end

  assign word_merge = acc_pix ? (acc_q | pix_bits) : acc_q;

  // Accumulator, slot counter and flip latch next state.
  always_comb begin
    acc_d  = acc_q;
    slot_d = slot_q;
    hf_d   = hf_q;
    if (acc_pix && (slot_q == '0)) hf_d = bus.H;
    if (close) begin
      acc_d  = '0;
      slot_d = '0;
    end else if (acc_pix) begin
      acc_d  = word_merge;
      slot_d = slot_q + 3'd1;
    end
  end

  // Group accumulation state.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      acc_q  <= '0;
      slot_q <= '0;
      hf_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      slot_q <= slot_d;
      hf_q   <= hf_d;
    end
  end

  crp_outreg u_outreg (
    .CLK_12M    (CLK_12M),
    .nRESET     (nRESET),
    .load_i     (close),
    .word_i     (word_merge),
    .cr_ready_i (bus.CR_READY),
    .cr_o       (bus.CR),
    .cr_valid_o (cr_valid),
    .wcnt_o     (bus.WCNT)
  );

  assign bus.CR_VALID  = cr_valid;
  assign bus.PIX_READY = pix_ready;

endmodule
